// File: rtl/hazard_pkg.sv
// Shared types and opcode decode helpers for the data-hazard resolver.
package hazard_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } trk_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        return !(opcode == OP_BRANCH || opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Scoreboard of in-flight register writers, one entry per stage from execute
// (entry 0) to writeback (entry NUM_STAGES-1).
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        freeze,
    input  trk_entry_t                  ins,
    output trk_entry_t [NUM_STAGES-1:0] entries
);

    // Shift toward writeback each unfrozen cycle; the oldest entry retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries <= '0;
        end else if (!freeze) begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                entries[i] <= entries[i-1];
            end
            entries[0] <= ins;
        end
    end

endmodule

// File: rtl/hazard_unit_param.sv
// Data-hazard resolver: forwarding selects, stall/bubble control and a
// saturating stall counter for the instruction held in decode.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | last unfrozen cycle let decode advance (or flushed it)
//   STALL | last unfrozen cycle held PC/decode and bubbled execute
module hazard_unit_param
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int FORWARD_EN   = 1,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      dec_ir,
    input  logic             dec_valid,
    input  logic             branch_taken,
    input  logic             freeze,
    output logic             pc_write,
    output logic             dec_en,
    output logic             ex_bubble,
    output logic             dec_flush,
    output logic [2:0]       fwd_rs1_sel,
    output logic [2:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] LOAD_LAT = 3'(LOAD_LATENCY);

    trk_entry_t [NUM_STAGES-1:0] trk;
    trk_entry_t                  ins;
    hz_state_t                   state;
    hz_state_t                   next_state;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] res1;
    logic [3:0] res2;
    logic       hazard;
    logic       stall_now;
    logic       unused_bits;

    assign opcode      = dec_ir[6:0];
    assign rd          = dec_ir[11:7];
    assign rs1         = dec_ir[19:15];
    assign rs2         = dec_ir[24:20];
    assign unused_bits = ^{dec_ir[31:25], dec_ir[14:12]};

    // Returns {hazard, sel}. The downward scan leaves the youngest (lowest
    // index) matching writer as the winner. A hazarding source reports sel 0.
    function automatic logic [3:0] resolve(
        input logic [4:0]                  rs,
        input logic                        used,
        input trk_entry_t [NUM_STAGES-1:0] ents
    );
        logic       hit;
        logic [2:0] k;
        logic       ld;
        logic [3:0] res;
        hit = 1'b0;
        k   = 3'd0;
        ld  = 1'b0;
        res = 4'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (ents[i].valid && ents[i].rd == rs) begin
                hit = 1'b1;
                k   = 3'(i);
                ld  = ents[i].is_load;
            end
        end
        if (used && rs != 5'd0 && hit) begin
            if (FORWARD_EN != 0 && (!ld || k >= LOAD_LAT)) begin
                res = {1'b0, 3'(k + 3'd1)};
            end else begin
                res = {1'b1, 3'd0};
            end
        end
        return res;
    endfunction

    // Per-source match against the tracker.
    always_comb begin
        res1   = resolve(rs1, uses_rs1(opcode), trk);
        res2   = resolve(rs2, uses_rs2(opcode), trk);
        hazard = dec_valid && (res1[3] || res2[3]);
    end

    // Next state and pipeline controls, reset > freeze > branch > hazard.
    always_comb begin
        pc_write    = 1'b1;
        dec_en      = 1'b1;
        ex_bubble   = 1'b0;
        dec_flush   = 1'b0;
        fwd_rs1_sel = 3'd0;
        fwd_rs2_sel = 3'd0;
        stall_now   = 1'b0;
        next_state  = RUN;
        if (rst_n) begin
            if (dec_valid) begin
                fwd_rs1_sel = res1[2:0];
                fwd_rs2_sel = res2[2:0];
            end
            if (freeze) begin
                pc_write   = 1'b0;
                dec_en     = 1'b0;
                next_state = state;
            end else if (branch_taken) begin
                dec_flush = 1'b1;
            end else if (hazard) begin
                pc_write   = 1'b0;
                dec_en     = 1'b0;
                ex_bubble  = 1'b1;
                stall_now  = 1'b1;
                next_state = STALL;
            end
        end
    end

    // Entry entering execute: only a real, advancing, unsquashed writer of a nonzero rd.
    always_comb begin
        ins = '0;
        if (dec_en && dec_valid && !branch_taken && writes_rd(opcode) && rd != 5'd0) begin
            ins.valid   = 1'b1;
            ins.rd      = rd;
            ins.is_load = (opcode == OP_LOAD);
        end
    end

    hazard_tracker #(
        .NUM_STAGES(NUM_STAGES)
    ) u_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .ins    (ins),
        .entries(trk)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Saturating count of hazard-stall cycles; freeze and branch cycles do not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_now && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // A stall always bubbles execute, so STALL never coexists with a live entry 0.
    always @(posedge clk) begin
        if (rst_n && state == STALL) begin
            assert (!trk[0].valid);
        end
    end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed, table-driven bench for hazard_unit_param across three parameter sets.
module tb_hazard_unit_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] dec_ir;
    logic        dec_valid;
    logic        branch_taken;
    logic        freeze;

    logic        pw_a, de_a, eb_a, df_a;
    logic [2:0]  s1_a, s2_a;
    logic [15:0] sc_a;
    logic        pw_b, de_b, eb_b, df_b;
    logic [2:0]  s1_b, s2_b;
    logic [15:0] sc_b;
    logic        pw_c, de_c, eb_c, df_c;
    logic [2:0]  s1_c, s2_c;
    logic [3:0]  sc_c;

    hazard_unit_param #(.NUM_STAGES(3), .FORWARD_EN(1), .LOAD_LATENCY(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .dec_ir(dec_ir), .dec_valid(dec_valid),
        .branch_taken(branch_taken), .freeze(freeze),
        .pc_write(pw_a), .dec_en(de_a), .ex_bubble(eb_a), .dec_flush(df_a),
        .fwd_rs1_sel(s1_a), .fwd_rs2_sel(s2_a), .stall_cycles(sc_a));

    hazard_unit_param #(.NUM_STAGES(3), .FORWARD_EN(0), .LOAD_LATENCY(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .dec_ir(dec_ir), .dec_valid(dec_valid),
        .branch_taken(branch_taken), .freeze(freeze),
        .pc_write(pw_b), .dec_en(de_b), .ex_bubble(eb_b), .dec_flush(df_b),
        .fwd_rs1_sel(s1_b), .fwd_rs2_sel(s2_b), .stall_cycles(sc_b));

    hazard_unit_param #(.NUM_STAGES(6), .FORWARD_EN(0), .LOAD_LATENCY(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .dec_ir(dec_ir), .dec_valid(dec_valid),
        .branch_taken(branch_taken), .freeze(freeze),
        .pc_write(pw_c), .dec_en(de_c), .ex_bubble(eb_c), .dec_flush(df_c),
        .fwd_rs1_sel(s1_c), .fwd_rs2_sel(s2_c), .stall_cycles(sc_c));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        r;
        logic [31:0] ir;
        logic        v;
        logic        br;
        logic        fz;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] op_add(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] op_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] op_lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] op_sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] op_beq(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'd0, 7'b1100011};
    endfunction
    // rs1 field bits are set to f even though LUI has no source operand.
    function automatic logic [31:0] op_lui(input int rd, input int f);
        return {12'd0, 5'(f), 3'd0, 5'(rd), 7'b0110111};
    endfunction

    task automatic add_vec(input logic r, input logic [31:0] ir, input logic v,
                           input logic br, input logic fz,
                           input logic pw, input logic de, input logic eb, input logic df,
                           input int s1, input int s2, input int sc);
        vec_t t;
        t.r   = r;
        t.ir  = ir;
        t.v   = v;
        t.br  = br;
        t.fz  = fz;
        t.exp = {pw, de, eb, df, 3'(s1), 3'(s2), 16'(sc)};
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        dec_ir       = NOP;
        dec_valid    = 1'b0;
        branch_taken = 1'b0;
        freeze       = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_table(input int which, input string name);
        logic [25:0] got;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n        = vecs[i].r;
            dec_ir       = vecs[i].ir;
            dec_valid    = vecs[i].v;
            branch_taken = vecs[i].br;
            freeze       = vecs[i].fz;
            #1;
            if (which == 0) got = {pw_a, de_a, eb_a, df_a, s1_a, s2_a, sc_a};
            else            got = {pw_b, de_b, eb_b, df_b, s1_b, s2_b, sc_b};
            n_checks++;
            if (got !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL %s row %0d: pw,de,eb,df,s1,s2,sc got %b%b%b%b %0d %0d %0d expected %b%b%b%b %0d %0d %0d",
                         name, i + 1, got[25], got[24], got[23], got[22], got[21:19], got[18:16], got[15:0],
                         vecs[i].exp[25], vecs[i].exp[24], vecs[i].exp[23], vecs[i].exp[22],
                         vecs[i].exp[21:19], vecs[i].exp[18:16], vecs[i].exp[15:0]);
            end
        end
        vecs.delete();
    endtask

    initial begin
        int stalls;
        int exp_sc;
        logic exp_eb;

        // Forwarding configuration: NUM_STAGES=3, FORWARD_EN=1, LOAD_LATENCY=1.
        //      r  ir                  v  br fz  pw de eb df s1 s2 sc
        add_vec(0, op_add(5,1,2),      1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(5,1,2),      1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(6,5,1),      1, 0, 0,  1, 1, 0, 0, 1, 0, 0);
        add_vec(1, op_add(7,5,6),      1, 0, 0,  1, 1, 0, 0, 2, 1, 0);
        add_vec(1, NOP,                1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(8,5,7),      1, 0, 0,  1, 1, 0, 0, 0, 2, 0);
        add_vec(1, NOP,                1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, NOP,                1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(0,8,0),      1, 0, 0,  1, 1, 0, 0, 3, 0, 0);
        add_vec(1, op_add(1,8,0),      1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_addi(0,0,5),     1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(1,0,0),      1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, NOP,                1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(5,1,1),      1, 0, 0,  1, 1, 0, 0, 2, 2, 0);
        add_vec(1, op_lui(9,5),        1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_lw(7,2),         1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_sw(7,2),         1, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        add_vec(1, op_sw(7,2),         1, 0, 0,  1, 1, 0, 0, 0, 2, 1);
        add_vec(1, op_add(3,7,7),      1, 0, 0,  1, 1, 0, 0, 3, 3, 1);
        add_vec(1, op_lw(4,3),         1, 0, 0,  1, 1, 0, 0, 1, 0, 1);
        add_vec(1, op_add(10,4,0),     1, 1, 0,  1, 1, 0, 1, 0, 0, 1);
        add_vec(1, op_add(10,4,0),     1, 0, 0,  1, 1, 0, 0, 2, 0, 1);
        add_vec(1, op_lw(11,0),        1, 0, 0,  1, 1, 0, 0, 0, 0, 1);
        add_vec(1, op_add(12,11,10),   1, 0, 1,  0, 0, 0, 0, 0, 2, 1);
        add_vec(1, op_add(12,11,10),   1, 0, 1,  0, 0, 0, 0, 0, 2, 1);
        add_vec(1, op_add(12,11,10),   1, 0, 0,  0, 0, 1, 0, 0, 2, 1);
        add_vec(1, op_add(12,11,10),   1, 0, 0,  1, 1, 0, 0, 2, 3, 2);
        add_vec(1, op_lw(13,0),        1, 0, 0,  1, 1, 0, 0, 0, 0, 2);
        add_vec(1, op_add(14,13,12),   1, 0, 0,  0, 0, 1, 0, 0, 2, 2);
        add_vec(0, op_add(14,13,12),   1, 0, 0,  1, 1, 0, 0, 0, 0, 3);
        add_vec(1, op_add(14,13,12),   1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(14,14,14),   0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(1,14,0),     1, 0, 0,  1, 1, 0, 0, 2, 0, 0);
        add_vec(1, op_add(2,1,0),      1, 1, 1,  0, 0, 0, 0, 1, 0, 0);
        do_reset();
        run_table(0, "fwd");

        // Legacy configuration: FORWARD_EN=0, freeze inserted mid-stall.
        add_vec(0, op_add(5,1,2),      1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_add(5,1,2),      1, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        add_vec(1, op_beq(5,0),        1, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        add_vec(1, op_beq(5,0),        1, 0, 1,  0, 0, 0, 0, 0, 0, 1);
        add_vec(1, op_beq(5,0),        1, 0, 0,  0, 0, 1, 0, 0, 0, 1);
        add_vec(1, op_beq(5,0),        1, 0, 0,  0, 0, 1, 0, 0, 0, 2);
        add_vec(1, op_beq(5,0),        1, 0, 0,  1, 1, 0, 0, 0, 0, 3);
        do_reset();
        run_table(1, "legacy");

        // Saturation: an instruction that reads and writes x5 stalls on itself
        // for NUM_STAGES=6 cycles after each issue, i.e. a period of 7 cycles.
        do_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        dec_ir    = op_add(5,5,1);
        dec_valid = 1'b1;
        stalls    = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            exp_eb = ((i % 7) != 0);
            exp_sc = (stalls > 15) ? 15 : stalls;
            n_checks++;
            if (eb_c !== exp_eb || pw_c !== !exp_eb || sc_c !== 4'(exp_sc)) begin
                n_fail++;
                $display("FAIL sat cycle %0d: eb,pw,sc got %b %b %0d expected %b %b %0d",
                         i, eb_c, pw_c, sc_c, exp_eb, !exp_eb, exp_sc);
            end
            if (exp_eb) stalls++;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
